// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: handshaked execute-stage ALU with iterative multiply/divide.
//   Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR/MFHI/MFLO) return one cycle after accept.
//   MULT/MULTU/DIV/DIVU run WIDTH shift-add / restoring shift-subtract iterations
//   on operand magnitudes and return WIDTH+1 cycles after accept. A divide by zero
//   skips iteration and returns two cycles after accept.
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_valid / o_ready       request handshake (accept = i_valid & o_ready)
//   i_data1, i_read2        operand A, register operand B
//   i_Instruction           immediate source (low IMM_WIDTH bits, sign-extended)
//   i_ALUSrc                1: B = immediate, 0: B = i_read2
//   i_ALUcontrol            opcode
//   o_valid                 one-cycle result pulse
//   o_ALUresult, o_Zero     result and result==0
//   o_divzero               divide-by-zero flag, valid with o_valid
//   o_hi, o_lo              HI/LO registers
module alu_seq_muldiv #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned IMM_WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_read2,
    input  logic [WIDTH-1:0] i_Instruction,
    input  logic             i_ALUSrc,
    input  logic [3:0]       i_ALUcontrol,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_ALUresult,
    output logic             o_Zero,
    output logic             o_divzero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MFHI = 4'b1101;
    localparam logic [3:0] OP_MFLO = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DZERO = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Architectural / output registers
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             divzero_q, divzero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Iteration working registers
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;      // multiplicand or divisor magnitude
    logic             is_div_q, is_div_d;
    logic             neg_main_q, neg_main_d; // sign of product / quotient
    logic             neg_rem_q, neg_rem_d;   // sign of remainder (sign of A)
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Request decode
    logic             accept;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] opb;
    logic             req_mul, req_div, req_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] alu_res;
    logic             unused_instr;

    assign unused_instr = ^i_Instruction;

    assign accept     = i_valid & o_ready;
    assign imm_ext    = WIDTH'($signed(i_Instruction[IMM_WIDTH-1:0]));
    assign opb        = i_ALUSrc ? imm_ext : i_read2;
    assign req_mul    = (i_ALUcontrol[3:1] == 3'b100);
    assign req_div    = (i_ALUcontrol[3:1] == 3'b101);
    assign req_signed = ~i_ALUcontrol[0];
    assign a_neg      = req_signed & i_data1[WIDTH-1];
    assign b_neg      = req_signed & opb[WIDTH-1];
    assign a_mag      = a_neg ? -i_data1 : i_data1;
    assign b_mag      = b_neg ? -opb : opb;

    // Single-cycle result
    always_comb begin
        alu_res = '0;
        case (i_ALUcontrol)
            OP_AND:  alu_res = i_data1 & opb;
            OP_OR:   alu_res = i_data1 | opb;
            OP_ADD:  alu_res = i_data1 + opb;
            OP_SUB:  alu_res = i_data1 - opb;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_data1) < $signed(opb))};
            OP_NOR:  alu_res = ~(i_data1 | opb);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // One iteration step plus final sign fix-up
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] mul_prod, mul_fixed;
    logic [WIDTH-1:0]   fin_hi, fin_lo;
    logic               last_iter;

    always_comb begin
        mul_sum   = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? opnd_q : '0)};
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        // Only the low WIDTH bits matter: when div_ge the true difference < divisor
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        div_ge    = (div_shift >= {1'b0, opnd_q});
        if (is_div_q) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {work_lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        end
        mul_prod  = {step_hi, step_lo};
        mul_fixed = neg_main_q ? -mul_prod : mul_prod;
        if (is_div_q) begin
            fin_hi = neg_rem_q  ? -step_hi : step_hi;
            fin_lo = neg_main_q ? -step_lo : step_lo;
        end else begin
            fin_hi = mul_fixed[2*WIDTH-1:WIDTH];
            fin_lo = mul_fixed[WIDTH-1:0];
        end
    end

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && req_mul)      state_d = ST_BUSY;
                else if (accept && req_div) state_d = (opb == '0) ? ST_DZERO : ST_BUSY;
            end
            ST_BUSY:  if (last_iter) state_d = ST_IDLE;
            ST_DZERO: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath next values
    always_comb begin
        o_ready    = (state_q == ST_IDLE);
        valid_d    = 1'b0;
        divzero_d  = 1'b0;
        result_d   = result_q;
        zero_d     = zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        work_hi_d  = work_hi_q;
        work_lo_d  = work_lo_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_mul) begin
                        work_hi_d  = '0;
                        work_lo_d  = b_mag;
                        opnd_d     = a_mag;
                        is_div_d   = 1'b0;
                        neg_main_d = a_neg ^ b_neg;
                        neg_rem_d  = 1'b0;
                        cnt_d      = '0;
                    end else if (req_div) begin
                        is_div_d   = 1'b1;
                        neg_main_d = a_neg ^ b_neg;
                        neg_rem_d  = a_neg;
                        cnt_d      = '0;
                        opnd_d     = b_mag;
                        if (opb == '0) begin
                            // Divide-by-zero result staged directly
                            work_hi_d = i_data1;
                            work_lo_d = '1;
                        end else begin
                            work_hi_d = '0;
                            work_lo_d = a_mag;
                        end
                    end else begin
                        valid_d  = 1'b1;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                    end
                end
            end
            ST_BUSY: begin
                work_hi_d = step_hi;
                work_lo_d = step_lo;
                cnt_d     = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    hi_d     = fin_hi;
                    lo_d     = fin_lo;
                    result_d = fin_lo;
                    zero_d   = (fin_lo == '0);
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                end
            end
            ST_DZERO: begin
                hi_d      = work_hi_q;
                lo_d      = work_lo_q;
                result_d  = work_lo_q;
                zero_d    = (work_lo_q == '0);
                valid_d   = 1'b1;
                divzero_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            divzero_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            work_hi_q  <= '0;
            work_lo_q  <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            divzero_q  <= divzero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            work_hi_q  <= work_hi_d;
            work_lo_q  <= work_lo_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_ALUresult = result_q;
    assign o_Zero      = zero_q;
    assign o_divzero   = divzero_q;
    assign o_hi        = hi_q;
    assign o_lo        = lo_q;

endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
Parametrised, handshaked successor to the single-cycle datapath ALU. It keeps the existing logic/arithmetic opcodes and adds iterative signed/unsigned multiply and divide, HI/LO result registers and move-from-HI/LO. It sits in the execute stage of the multi-cycle core. The controller holds off issue using o_ready.

Parameters:
WIDTH, 32, datapath width in bits (>=8).
IMM_WIDTH, 16, immediate field width taken from i_Instruction[IMM_WIDTH-1:0]; sign-extended to WIDTH.

Ports:
i_clk  input  1  rising-edge clock
i_rst  input  1  reset, asynchronous, active-high; clears all state
i_valid  input  1  operation request
o_ready  output  1  block can accept a request this cycle
i_data1  input  WIDTH  operand A
i_read2  input  WIDTH  register operand B
i_Instruction  input  WIDTH  instruction word (immediate source)
i_ALUSrc  input  1  1: B = sign-extended immediate; 0: B = i_read2
i_ALUcontrol  input  4  opcode
o_valid  output  1  one-cycle pulse: o_ALUresult/o_Zero valid
o_ALUresult  output  WIDTH  result
o_Zero  output  1  o_ALUresult == 0
o_divzero  output  1  set with o_valid when a divide had B == 0
o_hi  output  WIDTH  HI register
o_lo  output  WIDTH  LO register

Behaviour:
- Reset (async, i_rst=1): state IDLE, o_ready=1, o_valid=0, o_ALUresult=0, o_Zero=0 (not recomputed during reset), o_divzero=0, HI=LO=0, counter=0. Reset during BUSY aborts the operation with no o_valid.
- Accept = i_valid & o_ready. Operands and opcode are latched on accept. Input changes afterwards have no effect.
- Opcodes, single-cycle class:
  - 0000 AND, 0001 OR, 0010 ADD (mod 2^WIDTH), 0110 SUB (mod 2^WIDTH).
  - 0111 SLT: signed compare, result 1/0.
  - 1100 NOR: ~(A|B).
  - 1101 MFHI: result = HI. 1110 MFLO: result = LO.
  - Any other undefined code: result 0.
- Single-cycle latency: accept in cycle N -> o_valid=1 in N+1 with registered result. o_ready stays 1, so back-to-back issue gives o_valid every cycle.
- Multi-cycle class:
  - 1000 MULT (signed), 1001 MULTU: {HI,LO} = A*B, 2*WIDTH bits.
  - 1010 DIV (signed), 1011 DIVU: LO = quotient, HI = remainder.
- FSM for multi-cycle ops:
  - IDLE -> BUSY on accept. o_ready=0 from the next cycle.
  - BUSY performs WIDTH iterations of shift-add (mul) or restoring shift-subtract (div) on magnitudes, then fixes signs.
  - BUSY -> IDLE after iteration WIDTH: HI/LO update and o_valid=1 in the same cycle, with o_ALUresult = LO.
  - Latency from accept to o_valid is exactly WIDTH+1 cycles. o_ready returns to 1 in the o_valid cycle.
- Signed rules: quotient sign = sign(A) xor sign(B); remainder takes sign(A) (truncating division). MIN / -1 -> LO = MIN, HI = 0.
- Divide by zero (B == 0, both div ops): no iteration; o_valid 2 cycles after accept. HI = A, LO = all ones, o_divzero=1 for that o_valid cycle only.
- i_valid while o_ready=0 is ignored (not queued). The requester must hold it.
- o_Zero tracks o_ALUresult. o_ALUresult holds its last value between o_valid pulses.
- HI/LO are written only by mul/div completion. MFHI accepted in the same cycle as completion reads the new value (the request is accepted after the o_ready rise).

Test Plan:
- Reset mid-MULT (i_rst at iteration 10) -> no o_valid; o_ready=1, HI=LO=0, o_ALUresult=0 immediately (async).
- Back-to-back ADD 5+7, SUB 5-5, SLT -1<1, NOR 0,0 on consecutive cycles -> o_valid 4 consecutive cycles. Results 12 (o_Zero=0), 0 (o_Zero=1), 1, 0xFFFFFFFF.
- i_ALUSrc=1, i_Instruction[15:0]=0xFFFE, ADD with A=10 -> result 8. Same with 0x7FFF -> 0x8009.
- MULT 0xFFFFFFFD (-3) * 7 -> o_valid exactly 33 cycles after accept; HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU same operands -> HI=6, LO=0xFFFFFFEB. MFHI after each returns HI.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIVU 9/0 -> o_valid 2 cycles after accept, o_divzero=1, HI=9, LO=0xFFFFFFFF. i_valid held during BUSY is accepted only once o_ready=1.
